// File: rtl/cpu_types_pkg.sv
// Shared types for the per-core request unit.
//   req_state_t   : request sequencer states (FETCH, DATA, HALT)
//   reservation_t : LL/SC reservation {valid, addr}
// The reservation address is held at RES_ADDR_W bits and compared zero-extended,
// so any ADDR_W up to RES_ADDR_W matches exactly.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } req_state_t;

    localparam int unsigned RES_ADDR_W = 64;

    typedef struct packed {
        logic                  valid;
        logic [RES_ADDR_W-1:0] addr;
    } reservation_t;

endpackage

// File: rtl/req_watchdog.sv
// Data-request watchdog.
// Counts consecutive enabled cycles. expire is raised combinationally during the
// enabled cycle that would be the TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES = 0 disables it.
// Ports:
//   CLK, nRST : clock, asynchronous active-low reset
//   clear     : zero the count (request entering DATA)
//   enable    : count this cycle (DATA cycle without dhit)
//   expire    : limit reached this cycle
module req_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_wd;
            assign unused_wd = ^{CLK, nRST, clear, enable};
            assign expire    = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] count;

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= count + CNT_W'(1);
                end
            end

            assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_request_ctrl.sv
// Per-core memory request unit: serialises instruction fetch and data access
// toward the shared cache/bus interface.
// Optional LL/SC reservation tracking is built when RU_LLSC_EN is defined;
// otherwise ll_in/sc_in/snoop_* are ignored and sc_success reads 1.
// Ports:
//   CLK, nRST            : clock, asynchronous active-low reset
//   ihit, dhit           : fetch / data access completed this cycle
//   halt_in, mem_read, mem_write, ll_in, sc_in, addr_in, store_in : decode, valid with ihit
//   snoop_inv, snoop_addr: other core wrote snoop_addr
//   imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore : registered memory requests
//   pc_en                : combinational advance strobe
//   sc_success, is_halted, timeout_err : registered status
module mem_request_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              halt_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ll_in,
    input  logic              sc_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] store_in,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              pc_en,
    output logic              sc_success,
    output logic              is_halted,
    output logic              timeout_err
);

    req_state_t state;
    logic       start_data;
    logic       sc_fail;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;

    req_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Halt outranks any memory op; a failing SC completes without a DATA phase.
    always_comb begin
        start_data = (state == FETCH) && ihit && !halt_in && (mem_read || mem_write) && !sc_fail;
        pc_en      = ((state == FETCH) && ihit && !halt_in && !start_data) ||
                     ((state == DATA) && dhit);
        wd_clear   = start_data;
        wd_enable  = (state == DATA) && !dhit;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            imemREN     <= 1'b1;
            dmemREN     <= 1'b0;
            dmemWEN     <= 1'b0;
            dmemaddr    <= '0;
            dmemstore   <= '0;
            is_halted   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (ihit && halt_in) begin
                        state     <= HALT;
                        imemREN   <= 1'b0;
                        is_halted <= 1'b1;
                    end else if (start_data) begin
                        state     <= DATA;
                        imemREN   <= 1'b0;
                        dmemWEN   <= mem_write;
                        dmemREN   <= mem_read && !mem_write;
                        dmemaddr  <= addr_in;
                        dmemstore <= store_in;
                    end
                end
                DATA: begin
                    if (dhit) begin
                        state   <= FETCH;
                        imemREN <= 1'b1;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                    end else if (wd_expire) begin
                        state       <= HALT;
                        dmemREN     <= 1'b0;
                        dmemWEN     <= 1'b0;
                        is_halted   <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                    imemREN <= 1'b0;
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                    is_halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef RU_LLSC_EN
    reservation_t res;
    reservation_t res_next;
    logic         req_ll;
    logic         req_sc;
    logic         snoop_hit;
    logic         sc_ok;

    always_comb begin
        snoop_hit = snoop_inv && res.valid && (res.addr == RES_ADDR_W'(snoop_addr));
        // A snoop landing on the same cycle as the SC fetch kills the reservation first.
        sc_ok     = res.valid && (res.addr == RES_ADDR_W'(addr_in)) && !snoop_hit;
        sc_fail   = (state == FETCH) && ihit && !halt_in && mem_write && sc_in && !sc_ok;

        res_next = res;
        if ((state == DATA) && dhit) begin
            if (req_ll && dmemREN) begin
                res_next.valid = 1'b1;
                res_next.addr  = RES_ADDR_W'(dmemaddr);
            end else if (dmemWEN && (req_sc || (res.addr == RES_ADDR_W'(dmemaddr)))) begin
                res_next.valid = 1'b0;
            end
        end
        if (snoop_inv && res_next.valid && (res_next.addr == RES_ADDR_W'(snoop_addr))) begin
            res_next.valid = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            res        <= '0;
            req_ll     <= 1'b0;
            req_sc     <= 1'b0;
            sc_success <= 1'b0;
        end else begin
            res <= res_next;
            if (start_data) begin
                req_ll <= ll_in && mem_read && !mem_write;
                req_sc <= sc_in && mem_write;
            end
            if (sc_fail) begin
                sc_success <= 1'b0;
            end else if ((state == DATA) && dhit && req_sc) begin
                sc_success <= 1'b1;
            end
        end
    end
`else
    logic unused_llsc;
    assign unused_llsc = ^{ll_in, sc_in, snoop_inv, snoop_addr};
    assign sc_fail     = 1'b0;
    assign sc_success  = 1'b1;
`endif

endmodule

// File: tb/tb_mem_request_ctrl.sv
`timescale 1ns/1ps
module tb_mem_request_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;
`ifdef RU_LLSC_EN
    localparam logic SCR = 1'b0;
`else
    localparam logic SCR = 1'b1;
`endif

    logic          CLK = 1'b0;
    logic          nRST = 1'b1;
    logic          ihit, dhit, halt_in, mem_read, mem_write, ll_in, sc_in, snoop_inv;
    logic [AW-1:0] addr_in, snoop_addr;
    logic [DW-1:0] store_in;
    logic          imemREN, dmemREN, dmemWEN, pc_en, sc_success, is_halted, timeout_err;
    logic [AW-1:0] dmemaddr;
    logic [DW-1:0] dmemstore;

    mem_request_ctrl #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .halt_in     (halt_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ll_in       (ll_in),
        .sc_in       (sc_in),
        .addr_in     (addr_in),
        .store_in    (store_in),
        .snoop_inv   (snoop_inv),
        .snoop_addr  (snoop_addr),
        .imemREN     (imemREN),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .pc_en       (pc_en),
        .sc_success  (sc_success),
        .is_halted   (is_halted),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        imem, dren, dwen, halted, terr, scs, pc;
        logic [31:0] addr, store;
    } obs_t;

    typedef struct packed {
        logic        ih, dh, hl, rd, wr, ll, sc, sn;
        logic [31:0] addr, store, saddr;
    } stim_t;

    obs_t  sb[$];
    stim_t stq[$];
    int    checks = 0;
    int    errors = 0;
    obs_t  got, want;

    function automatic obs_t e(input logic imem, dren, dwen, halted, terr, scs, pc,
                               input logic [31:0] a, st);
        obs_t o;
        o = '{imem, dren, dwen, halted, terr, scs, pc, a, st};
        return o;
    endfunction

    function automatic stim_t s(input logic ih, dh, hl, rd, wr, ll, sc, sn,
                                input logic [31:0] a, st, sa);
        stim_t x;
        x = '{ih, dh, hl, rd, wr, ll, sc, sn, a, st, sa};
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{imemREN, dmemREN, dmemWEN, is_halted, timeout_err, sc_success, pc_en,
              dmemaddr, dmemstore};
        return o;
    endfunction

    task automatic drive(input stim_t x);
        ihit = x.ih; dhit = x.dh; halt_in = x.hl; mem_read = x.rd; mem_write = x.wr;
        ll_in = x.ll; sc_in = x.sc; snoop_inv = x.sn;
        addr_in = x.addr; store_in = x.store; snoop_addr = x.saddr;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        drive(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        drive(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2 nRST = 1'b0;
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 0, 0));
        #1;
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL test_reset: got %h expected %h", got, want);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_nop();
        int n = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            stq.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 32'h100 + i, 0, 0));
            sb.push_back(e(1, 0, 0, 0, 0, SCR, 1, 0, 0));
        end
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 0, 0));
        while (stq.size() > 0) begin
            @(negedge CLK); drive(stq.pop_front()); #1;
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL test_nop cycle %0d: got %h expected %h", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_read();
        int n = 0;
        apply_reset();
        stq.push_back(s(1, 1, 0, 1, 0, 0, 0, 0, 32'h40, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 0, 0));
        stq.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0, 0));
        sb.push_back(e(0, 1, 0, 0, 0, SCR, 0, 32'h40, 0));
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 1, 0, 0, 0, SCR, 0, 32'h40, 0));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 1, 0, 0, 0, SCR, 1, 32'h40, 0));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 32'h40, 0));
        while (stq.size() > 0) begin
            @(negedge CLK); drive(stq.pop_front()); #1;
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL test_read cycle %0d: got %h expected %h", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_write_wins();
        int n = 0;
        apply_reset();
        stq.push_back(s(1, 0, 0, 1, 1, 0, 0, 0, 32'h44, 32'hDEADBEEF, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 0, 0));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 0, 1, 0, 0, SCR, 1, 32'h44, 32'hDEADBEEF));
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 32'h44, 32'hDEADBEEF));
        while (stq.size() > 0) begin
            @(negedge CLK); drive(stq.pop_front()); #1;
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL test_write_wins cycle %0d: got %h expected %h", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_watchdog_dhit_last();
        int n = 0;
        apply_reset();
        stq.push_back(s(1, 0, 0, 0, 1, 0, 0, 0, 32'h48, 32'h1234, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            sb.push_back(e(0, 0, 1, 0, 0, SCR, 0, 32'h48, 32'h1234));
        end
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 0, 1, 0, 0, SCR, 1, 32'h48, 32'h1234));
        // A second request must start with a cleared count.
        stq.push_back(s(1, 0, 0, 1, 0, 0, 0, 0, 32'h50, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 32'h48, 32'h1234));
        for (int i = 0; i < 3; i++) begin
            stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            sb.push_back(e(0, 1, 0, 0, 0, SCR, 0, 32'h50, 0));
        end
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 1, 0, 0, 0, SCR, 1, 32'h50, 0));
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 32'h50, 0));
        while (stq.size() > 0) begin
            @(negedge CLK); drive(stq.pop_front()); #1;
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL test_watchdog_dhit_last cycle %0d: got %h expected %h",
                                   n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_llsc();
        int n = 0;
        apply_reset();
`ifdef RU_LLSC_EN
        stq.push_back(s(1, 0, 0, 1, 0, 1, 0, 0, 32'h80, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 0, 0, 0, 0));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 1, 0, 0, 0, 0, 1, 32'h80, 0));
        stq.push_back(s(1, 0, 0, 0, 1, 0, 1, 0, 32'h80, 32'h55, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 0, 0, 32'h80, 0));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 0, 1, 0, 0, 0, 1, 32'h80, 32'h55));
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 1, 0, 32'h80, 32'h55));
        stq.push_back(s(1, 0, 0, 1, 0, 1, 0, 0, 32'h80, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 1, 0, 32'h80, 32'h55));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 1, 0, 0, 0, 1, 1, 32'h80, 0));
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80));
        sb.push_back(e(1, 0, 0, 0, 0, 1, 0, 32'h80, 0));
        stq.push_back(s(1, 0, 0, 0, 1, 0, 1, 0, 32'h80, 32'h66, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 1, 1, 32'h80, 0));
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 0, 0, 32'h80, 0));
        stq.push_back(s(1, 0, 0, 1, 0, 1, 0, 0, 32'h84, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 0, 0, 32'h80, 0));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 1, 0, 0, 0, 0, 1, 32'h84, 0));
        stq.push_back(s(1, 0, 0, 0, 1, 0, 1, 1, 32'h84, 32'h77, 32'h84));
        sb.push_back(e(1, 0, 0, 0, 0, 0, 1, 32'h84, 0));
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 0, 0, 32'h84, 0));
`else
        // Without reservation tracking an SC is a plain store.
        stq.push_back(s(1, 0, 0, 0, 1, 0, 1, 1, 32'h90, 32'h55, 32'h90));
        sb.push_back(e(1, 0, 0, 0, 0, 1, 0, 0, 0));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 0, 1, 0, 0, 1, 1, 32'h90, 32'h55));
        stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(1, 0, 0, 0, 0, 1, 0, 32'h90, 32'h55));
`endif
        while (stq.size() > 0) begin
            @(negedge CLK); drive(stq.pop_front()); #1;
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL test_llsc cycle %0d: got %h expected %h", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_request();
        apply_reset();
        @(negedge CLK);
        drive(s(1, 0, 0, 1, 0, 0, 0, 0, 32'h60, 32'h7, 0));
        @(negedge CLK);
        drive(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 1, 0, 0, 0, SCR, 0, 32'h60, 32'h7));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 0, 0));
        #1;
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL test_reset_mid_request before: got %h expected %h", got, want);
        end
        nRST = 1'b0;
        #1;
        got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            errors++; $display("FAIL test_reset_mid_request after: got %h expected %h", got, want);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_halt();
        int n = 0;
        apply_reset();
        stq.push_back(s(1, 0, 1, 0, 1, 0, 0, 0, 32'h10, 32'h99, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 0, 0));
        stq.push_back(s(1, 1, 0, 1, 0, 0, 0, 0, 32'h14, 0, 0));
        sb.push_back(e(0, 0, 0, 1, 0, SCR, 0, 0, 0));
        stq.push_back(s(1, 0, 0, 0, 1, 0, 0, 0, 32'h18, 32'h5, 0));
        sb.push_back(e(0, 0, 0, 1, 0, SCR, 0, 0, 0));
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 0, 0, 1, 0, SCR, 0, 0, 0));
        while (stq.size() > 0) begin
            @(negedge CLK); drive(stq.pop_front()); #1;
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL test_halt cycle %0d: got %h expected %h", n, got, want);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        apply_reset();
        stq.push_back(s(1, 0, 0, 0, 1, 0, 0, 0, 32'h4C, 32'hCAFE, 0));
        sb.push_back(e(1, 0, 0, 0, 0, SCR, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            stq.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            sb.push_back(e(0, 0, 1, 0, 0, SCR, 0, 32'h4C, 32'hCAFE));
        end
        stq.push_back(s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(e(0, 0, 0, 1, 1, SCR, 0, 32'h4C, 32'hCAFE));
        stq.push_back(s(1, 0, 0, 1, 0, 0, 0, 0, 32'h20, 0, 0));
        sb.push_back(e(0, 0, 0, 1, 1, SCR, 0, 32'h4C, 32'hCAFE));
        while (stq.size() > 0) begin
            @(negedge CLK); drive(stq.pop_front()); #1;
            got = sample(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++; $display("FAIL test_timeout cycle %0d: got %h expected %h", n, got, want);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_read();
        test_write_wins();
        test_watchdog_dhit_last();
        test_llsc();
        test_reset_mid_request();
        test_halt();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_request_ctrl.md
Name: mem_request_ctrl

Overview:
- Next-generation request unit for each core of the dual-core datapath; sequences instruction-fetch and data-memory enables toward the cache/bus interface.
- Replaces free-running enable flags with an explicit FSM that serialises fetch and data access, which is required for the shared bus.
- Latches data address and store value for the life of a request.
- Adds a data-request watchdog and optional LL/SC reservation tracking for inter-core atomics.

Parameters:
ADDR_W, 32, width of data address
DATA_W, 32, width of store data
TIMEOUT_CYCLES, 1024, max cycles in DATA before timeout; 0 disables the watchdog

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous, active-low reset
ihit  input  1  instruction fetch completed this cycle
dhit  input  1  data access completed this cycle
halt_in  input  1  decoded halt instruction; valid with ihit
mem_read  input  1  decoded load; valid with ihit
mem_write  input  1  decoded store; valid with ihit
ll_in  input  1  load is load-linked; valid with ihit
sc_in  input  1  store is store-conditional; valid with ihit
addr_in  input  ADDR_W  data address; valid with ihit
store_in  input  DATA_W  store data; valid with ihit
snoop_inv  input  1  other core wrote snoop_addr this cycle
snoop_addr  input  ADDR_W  address written by other core
imemREN  output  1  instruction read enable (registered)
dmemREN  output  1  data read enable (registered)
dmemWEN  output  1  data write enable (registered)
dmemaddr  output  ADDR_W  latched data address (registered)
dmemstore  output  DATA_W  latched store data (registered)
pc_en  output  1  PC/pipeline may advance this cycle (combinational)
sc_success  output  1  result of last SC, 1 = succeeded (registered)
is_halted  output  1  core halted (registered)
timeout_err  output  1  sticky watchdog error (registered)

Behaviour:
Reset values:
- imemREN=1; all other outputs 0.
- State FETCH; watchdog count 0; reservation invalid.

State FETCH (imemREN=1, dmemREN=dmemWEN=0):
- ihit & halt_in: go to HALT. Halt has priority over any memory op in the same cycle.
- ihit & (mem_read | mem_write): go to DATA next edge.
  - Latch addr_in into dmemaddr and store_in into dmemstore.
  - Next cycle: imemREN=0; dmemWEN=mem_write; dmemREN=mem_read & !mem_write. Write wins if both are set.
- ihit with no op: stay in FETCH; pc_en=1 that cycle.
- dhit in FETCH: ignored.

State DATA (imemREN=0; enables held; dmemaddr/dmemstore stable):
- dhit: pc_en=1 this cycle. Next edge: dmemREN=dmemWEN=0, imemREN=1, go to FETCH.
- ihit in DATA: ignored.

Watchdog (active only when TIMEOUT_CYCLES != 0):
- Count clears on entry to DATA and increments on each DATA cycle without dhit.
- After TIMEOUT_CYCLES consecutive DATA cycles without dhit: go to HALT with timeout_err=1.
- dhit in the final cycle wins; no error is raised.

State HALT:
- is_halted=1; imemREN=dmemREN=dmemWEN=0; pc_en=0.
- Terminal until nRST. timeout_err stays sticky.

Latency:
- Non-memory instruction: advances on the ihit cycle.
- Memory instruction: ihit cycle plus at least one DATA cycle, advancing on the dhit cycle.

Reset mid-request: all enables drop asynchronously and the unit returns to FETCH with imemREN=1.

Optional Feature:
Macro RU_LLSC_EN.

Defined:
- Load with ll_in: on dhit, reservation <= {valid=1, addr=dmemaddr}.
- Store with sc_in, reservation valid and addr_in match: normal write; on dhit, sc_success=1 and reservation cleared.
- Store with sc_in and no valid/matching reservation: no DATA state, dmemWEN never asserted. pc_en=1 on the ihit cycle; sc_success=0 next edge.
- snoop_inv with snoop_addr == reservation addr clears the reservation. If it coincides with an SC ihit, the snoop wins and the SC fails.
- A plain store by this core to the reserved address clears the reservation on dhit.

Undefined:
- ll_in, sc_in, snoop_inv and snoop_addr are ignored.
- SC behaves as a plain store; sc_success tied 1.

Decomposition:
- cpu_types_pkg gains typedef enum logic [1:0] req_state_t {FETCH, DATA, HALT}.
- cpu_types_pkg also gains the reservation struct {valid, addr}.
- Sub-module req_watchdog: parametrised counter with clear, enable and expire signals; width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. Reset, then ihit with no op for 3 cycles -> imemREN=1 throughout; pc_en=1 each ihit; dmemREN=dmemWEN=0.
2. ihit, mem_read=1, addr_in=0x0000_0040; dhit 3 cycles later -> dmemREN=1 and dmemaddr=0x40 for exactly 3 cycles; imemREN=0 meanwhile; pc_en only on the dhit cycle; then imemREN=1.
3. ihit with mem_read=mem_write=1, store_in=0xDEADBEEF -> dmemWEN=1, dmemREN=0, dmemstore=0xDEADBEEF.
4. ihit with halt_in=1 and mem_write=1 -> HALT next edge; is_halted=1; all enables 0; later ihit/dhit have no effect.
5. TIMEOUT_CYCLES=4, store with no dhit -> after 4 DATA cycles timeout_err=1, is_halted=1. Repeat with dhit on cycle 4 -> no error.
6. RU_LLSC_EN: LL to 0x80 with dhit, then SC to 0x80 -> write issued, sc_success=1. Repeat with snoop_inv@0x80 before the SC -> no dmemWEN, sc_success=0.
